// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: address width, instruction size, NOP encoding
// and the fetch controller state type.
package riscv_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT,
    FAULT
  } fetch_state_t;
endpackage

// File: rtl/if_id_stage_reg.sv
// IF/ID output register with valid/ready handshake and flush.
// The caller only asserts load when the stage is free.
module if_id_stage_reg #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            load,
  input  logic            ready,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instruction,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instruction
);
  import riscv_pkg::*;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid       <= 1'b0;
      pc          <= '0;
      instruction <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      pc          <= load_pc;
      instruction <= load_instruction;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally and
// feeds decode through an IF/ID register; handles redirects, end of memory and faults.
module instruction_fetch_unit #(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_BYTES = 132
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] inst_addr,
  input  logic [31:0]     inst_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instruction,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     fetch_count
);
  import riscv_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN:0]   pc_end;
  logic            xfer;
  logic            free;
  logic            redirect_take;
  logic            redirect_ok;
  logic            past_end;
  logic            capture;

  assign inst_addr     = pc;
  assign xfer          = if_valid && if_ready;
  assign free          = !if_valid || if_ready;
  assign redirect_take = redirect_valid && (state == FETCH || state == HALT);
  assign redirect_ok   = (redirect_pc[1:0] == 2'b00);
  // One extra bit so a PC near the top of the address space cannot wrap into range.
  assign pc_end        = {1'b0, pc} + (XLEN+1)'(INST_BYTES);
  assign past_end      = pc_end > (XLEN+1)'(IMEM_BYTES);
  assign capture       = (state == FETCH) && free && !redirect_take && !past_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (xfer && fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;

      if (redirect_take) begin
        halted <= 1'b0;
        if (redirect_ok) begin
          pc    <= redirect_pc;
          state <= FETCH;
        end else begin
          state <= FAULT;
          fault <= 1'b1;
        end
      end else begin
        case (state)
          BOOT:  state <= FETCH;
          FETCH: begin
            if (free) begin
              if (past_end) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc + XLEN'(INST_BYTES);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  if_id_stage_reg #(
    .XLEN(XLEN)
  ) u_stage (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (redirect_take),
    .load             (capture),
    .ready            (if_ready),
    .load_pc          (pc),
    .load_instruction (inst_rdata),
    .valid            (if_valid),
    .pc               (if_pc),
    .instruction      (if_instruction)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then randomized traffic
// compared cycle by cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;
  localparam int unsigned IMEM = 132;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_instruction;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:32];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic [31:0] m_count;
  bit          m_valid, m_boot, m_halt, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a[1:0] == 2'b00 && a <= 64'(IMEM - 4))
      return mem[a[7:2]];
    return 32'hBAD0_0000 ^ a[31:0];
  endfunction

  assign inst_rdata = mem_word(inst_addr);

  instruction_fetch_unit #(
    .XLEN       (64),
    .RESET_PC   (64'h0),
    .IMEM_BYTES (IMEM)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .inst_addr      (inst_addr),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_if_pc = 64'h0; m_if_instr = NOP_W; m_count = 0;
    m_valid = 0; m_boot = 1; m_halt = 0; m_fault = 0;
  endtask

  // One clock of the fetch rules: redirect beats capture, stopped modes do not capture.
  task automatic model_step();
    bit xfer, free;
    xfer = m_valid && if_ready;
    free = !m_valid || if_ready;
    if (xfer && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_fault) begin
      m_valid = 0;
    end else if (redirect_valid) begin
      m_valid = 0;
      m_halt  = 0;
      if (redirect_pc % 4 == 0) m_pc = redirect_pc;
      else m_fault = 1;
    end else if (m_halt) begin
      if (xfer) m_valid = 0;
    end else if (free) begin
      if ({1'b0, m_pc} + 65'd4 > 65'(IMEM)) begin
        m_halt  = 1;
        m_valid = 0;
      end else begin
        m_valid    = 1;
        m_if_pc    = m_pc;
        m_if_instr = mem_word(m_pc);
        m_pc       = m_pc + 64'd4;
      end
    end
  endtask

  task automatic compare_all();
    check("inst_addr", inst_addr, m_pc);
    check("if_valid", 64'(if_valid), 64'(m_valid));
    if (m_valid) begin
      check("if_pc", if_pc, m_if_pc);
      check("if_instruction", 64'(if_instruction), 64'(m_if_instr));
    end
    check("halted", 64'(halted), 64'(m_halt));
    check("fault", 64'(fault), 64'(m_fault));
    check("fetch_count", 64'(fetch_count), 64'(m_count));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(if_valid), 64'd0);
    check({tag, "_if_pc"}, if_pc, 64'd0);
    check({tag, "_instr"}, 64'(if_instruction), 64'(NOP_W));
    check({tag, "_halted"}, 64'(halted), 64'd0);
    check({tag, "_fault"}, 64'(fault), 64'd0);
    check({tag, "_count"}, 64'(fetch_count), 64'd0);
    check({tag, "_addr"}, inst_addr, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i <= 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0285_3483;
    model_reset();

    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n  = 1'b1;
    if_ready = 1'b1;

    // Boot bubble, then one word per cycle
    tick();
    check("boot_valid", 64'(if_valid), 64'd0);
    tick();
    check("first_valid", 64'(if_valid), 64'd1);
    check("first_pc", if_pc, 64'd0);
    check("first_instr", 64'(if_instruction), 64'h0285_3483);
    tick();
    check("second_pc", if_pc, 64'd4);
    tick();
    check("third_pc", if_pc, 64'd8);
    check("third_count", 64'(fetch_count), 64'd2);

    // Backpressure
    if_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_pc", if_pc, 64'd8);
      check("bp_addr", inst_addr, 64'd12);
    end
    if_ready = 1'b1;
    tick();
    check("after_bp_pc", if_pc, 64'd12);
    tick();
    check("hold16_pc", if_pc, 64'd16);

    // Redirect under backpressure flushes the held word
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_valid = 1'b0;
    check("flush_valid", 64'(if_valid), 64'd0);
    check("flush_count", 64'(fetch_count), 64'd4);
    if_ready = 1'b1;
    tick();
    check("redir_pc", if_pc, 64'h40);

    // Misaligned redirect is sticky; a later aligned redirect is ignored
    redirect_valid = 1'b1; redirect_pc = 64'h42;
    tick();
    check("fault_set", 64'(fault), 64'd1);
    check("fault_valid", 64'(if_valid), 64'd0);
    redirect_pc = 64'h0;
    tick();
    redirect_valid = 1'b0;
    check("fault_sticky", 64'(fault), 64'd1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("fault_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Run to the end of memory
    for (int i = 0; i < 100 && !halted; i++) tick();
    check("eom_halted", 64'(halted), 64'd1);
    check("eom_last_pc", if_pc, 64'd128);
    check("eom_valid", 64'(if_valid), 64'd0);
    check("eom_addr", inst_addr, 64'd132);
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    tick();
    redirect_valid = 1'b0;
    check("restart_halted", 64'(halted), 64'd0);
    tick();
    check("restart_pc", if_pc, 64'd0);
    check("restart_valid", 64'(if_valid), 64'd1);

    // Asynchronous reset while a word is held
    tick();
    if_ready = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async");
    @(negedge clk);
    reset_n  = 1'b1;
    if_ready = 1'b1;
    tick();
    tick();
    check("async_resume_pc", if_pc, 64'd0);
    tick();
    check("async_next_pc", if_pc, 64'd4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rand_rst");
        @(negedge clk);
        reset_n = 1'b1;
      end
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 64'($urandom_range(0, 40) * 4);
      if ($urandom_range(0, 9) == 0) redirect_pc = redirect_pc + 64'($urandom_range(1, 3));
      tick();
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
